// File: rtl/pc_stack_pkg.sv
// Shared constants for the program counter with return-address stack.
// Operation select codes and select width used by pc_stack and its bench.
package pc_stack_pkg;
   localparam int SEL_SIZE = 3;

   localparam logic [SEL_SIZE-1:0] NEXT_INSTR   = 3'd0;
   localparam logic [SEL_SIZE-1:0] KEEP_INSTR   = 3'd1;
   localparam logic [SEL_SIZE-1:0] LOAD_INSTR   = 3'd2;
   localparam logic [SEL_SIZE-1:0] BRANCH_INSTR = 3'd3;
   localparam logic [SEL_SIZE-1:0] CALL_INSTR   = 3'd4;
   localparam logic [SEL_SIZE-1:0] RET_INSTR    = 3'd5;
endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: write pointer plus occupancy counter over a small memory.
// PC_STACK_GUARD_EN refuses push-when-full / pop-when-empty and flags a sticky err.
module ras_lifo #(
   parameter int ADDR_SIZE = 14,
   parameter int DEPTH     = 4,
   localparam int PW       = $clog2(DEPTH),
   localparam int DW       = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [ADDR_SIZE-1:0] din,
   output logic [ADDR_SIZE-1:0] dout,
   output logic [DW-1:0]        depth,
   output logic                 full,
   output logic                 empty,
   output logic                 err
);
   localparam logic [PW-1:0] WP_ONE = PW'(1);
   localparam logic [DW-1:0] D_ONE  = DW'(1);
   localparam logic [DW-1:0] D_MAX  = DW'(DEPTH);

   logic [ADDR_SIZE-1:0] mem [DEPTH];
   logic [PW-1:0]        wp;
   logic [DW-1:0]        cnt;
   logic                 do_push, do_pop;

   assign depth = cnt;
   assign full  = (cnt == D_MAX);
   assign empty = (cnt == '0);
   // Reading below wp with no valid entry returns whatever was last left there.
   assign dout  = mem[wp - WP_ONE];

`ifdef PC_STACK_GUARD_EN
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if ((push & full) | (pop & empty))
         err <= 1'b1;
   end
`else
   assign do_push = push;
   assign do_pop  = pop;
   assign err     = 1'b0;
`endif

   // Counter saturates at both ends; wp always wraps so overflow drops the oldest entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         cnt <= '0;
      end else if (do_push) begin
         wp <= wp + WP_ONE;
         if (!full) cnt <= cnt + D_ONE;
      end else if (do_pop) begin
         wp <= wp - WP_ONE;
         if (!empty) cnt <= cnt - D_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

// File: rtl/pc_stack.sv
// Fetch-stage program counter with next/keep/load/branch/call/return.
// Optional overflow/underflow guarding is enabled by PC_STACK_GUARD_EN.
module pc_stack
   import pc_stack_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_SIZE = 14,
   parameter int DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SEL_SIZE-1:0]          sel,
   input  logic [WORD_SIZE-1:0]         instr,
   output logic [ADDR_SIZE-1:0]         out,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full,
   output logic                         err
);
   localparam logic [ADDR_SIZE-1:0] PC_ONE = ADDR_SIZE'(1);

   logic [ADDR_SIZE-1:0] tgt, pc_inc, ret_pc, nxt;
   logic                 push, pop, call_ok, ret_ok;

   assign tgt    = instr[ADDR_SIZE-1:0];
   assign pc_inc = out + PC_ONE;
   assign push   = (sel == CALL_INSTR);
   assign pop    = (sel == RET_INSTR);

   generate
      if (WORD_SIZE > ADDR_SIZE) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^instr[WORD_SIZE-1:ADDR_SIZE];
      end
   endgenerate

`ifdef PC_STACK_GUARD_EN
   assign call_ok = ~full;
   assign ret_ok  = ~empty;
`else
   assign call_ok = 1'b1;
   assign ret_ok  = 1'b1;
`endif

   ras_lifo #(.ADDR_SIZE(ADDR_SIZE), .DEPTH(DEPTH)) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (ret_pc),
      .depth (depth),
      .full  (full),
      .empty (empty),
      .err   (err)
   );

   // Branch offset is two's complement, so a plain modular add covers both directions.
   always_comb begin
      nxt = out;
      case (sel)
         NEXT_INSTR:   nxt = pc_inc;
         LOAD_INSTR:   nxt = tgt;
         BRANCH_INSTR: nxt = out + tgt;
         CALL_INSTR:   nxt = call_ok ? tgt : out;
         RET_INSTR:    nxt = ret_ok ? ret_pc : out;
         default:      nxt = out;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) out <= '0;
      else     out <= nxt;
   end
endmodule
